lru_button_encoder: RTL and testbench

- Front end that produces the button-press events consumed by the LRU tracker.
- Synchronizes and debounces four raw push-buttons, detects press (rising) edges and buffers one pending press per button.
- Offers pressed button IDs one at a time on a valid/ready handshake, using the tracker's ID encoding (1..4, 0 = none).
- Absorbs the rate mismatch with the tracker's slow timed clock domain; the consumer acknowledges with ready.

---
 rtl/lru_pkg.sv | 42 ++++
 rtl/lru_button_encoder_debounce.sv | 49 ++++
 rtl/lru_button_encoder.sv | 95 +++++++++
 tb/tb_lru_button_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Button ID encoding and encoder FSM states shared by the button front end and the LRU tracker.
// Helpers map between pending-bit masks and IDs; ID 0 means no button.
package lru_pkg;

    typedef logic [2:0] button_id_t;

    localparam button_id_t ID_NONE = 3'd0;
    localparam button_id_t ID_B1   = 3'd1;
    localparam button_id_t ID_B2   = 3'd2;
    localparam button_id_t ID_B3   = 3'd3;
    localparam button_id_t ID_B4   = 3'd4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

    // Lowest index wins, so b1 has the highest priority.
    function automatic button_id_t lowest_pending(input logic [3:0] p);
        button_id_t id;
        id = ID_NONE;
        if (p[0])      id = ID_B1;
        else if (p[1]) id = ID_B2;
        else if (p[2]) id = ID_B3;
        else if (p[3]) id = ID_B4;
        return id;
    endfunction

    function automatic logic [3:0] id_mask(input button_id_t id);
        logic [3:0] m;
        m = 4'b0000;
        case (id)
            ID_B1:   m = 4'b0001;
            ID_B2:   m = 4'b0010;
            ID_B3:   m = 4'b0100;
            ID_B4:   m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lru_button_encoder_debounce.sv
// One button: 2-flop synchronizer plus counter debounce; held changes DEBOUNCE_CYCLES+2 edges
// after a clean input change. No backpressure, the level simply follows the filtered input.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + CNT_W'(1);
        held_d  = held_q;
        cnt_d   = cnt_inc;
        // Any sample agreeing with the current level restarts the count.
        if (sync2_q == held_q) begin
            cnt_d = '0;
        end else if (cnt_inc == CNT_MAX) begin
            cnt_d  = '0;
            held_d = ~held_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    assign held = held_q;

endmodule

// File: rtl/lru_button_encoder.sv
// Debounces four buttons, latches one pending press per button and offers IDs on valid/ready.
// press_valid rises DEBOUNCE_CYCLES+4 edges after a clean press; the offer is held until ready.
module lru_button_encoder
    import lru_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [2:0] press_id,
    output logic [3:0] held
);

    logic [3:0] btn_raw;
    logic [3:0] held_w;
    logic [3:0] held_prev_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] rise;
    logic [3:0] clr;
    enc_state_t state_q, state_d;
    logic       press_valid_q, press_valid_d;
    button_id_t press_id_q, press_id_d;

    assign btn_raw = {b4, b3, b2, b1};

    for (genvar i = 0; i < 4; i++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .held (held_w[i])
        );
    end

    always_comb begin
        rise          = held_w & ~held_prev_q;
        clr           = 4'b0000;
        state_d       = state_q;
        press_valid_d = press_valid_q;
        press_id_d    = press_id_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    press_id_d    = lowest_pending(pending_q);
                    press_valid_d = 1'b1;
                    state_d       = OFFER;
                end
            end
            OFFER: begin
                if (press_ready) begin
                    clr           = id_mask(press_id_q);
                    press_valid_d = 1'b0;
                    press_id_d    = ID_NONE;
                    state_d       = IDLE;
                end
            end
            default: begin
                press_valid_d = 1'b0;
                press_id_d    = ID_NONE;
                state_d       = IDLE;
            end
        endcase
        // A re-press landing on the accept edge survives, so that button is offered again.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_prev_q   <= 4'b0000;
            pending_q     <= 4'b0000;
            state_q       <= IDLE;
            press_valid_q <= 1'b0;
            press_id_q    <= ID_NONE;
        end else begin
            held_prev_q   <= held_w;
            pending_q     <= pending_d;
            state_q       <= state_d;
            press_valid_q <= press_valid_d;
            press_id_q    <= press_id_d;
        end
    end

    assign press_valid = press_valid_q;
    assign press_id    = press_id_q;
    assign held        = held_w;

endmodule

// File: tb/tb_lru_button_encoder.sv
module tb_lru_button_encoder;

    logic       clk;
    logic       rst;
    logic       b1, b2, b3, b4;
    logic       press_ready;
    logic       press_valid;
    logic [2:0] press_id;
    logic [3:0] held;

    int n_checks;
    int n_fail;

    lru_button_encoder #(
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .b1          (b1),
        .b2          (b2),
        .b3          (b3),
        .b4          (b4),
        .press_ready (press_ready),
        .press_valid (press_valid),
        .press_id    (press_id),
        .held        (held)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (press_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %b expected 0", press_valid); n_fail++;
        end
        n_checks++;
        if (press_id !== 3'd0) begin
            $display("FAIL reset_id: got %0d expected 0", press_id); n_fail++;
        end
        n_checks++;
        if (held !== 4'b0000) begin
            $display("FAIL reset_held: got %b expected 0000", held); n_fail++;
        end
        tick; tick;
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick;
            n_checks++;
            if (press_valid !== 1'b0 || held !== 4'b0000) begin
                $display("FAIL post_reset_idle edge %0d: valid %b held %b expected 0 0000", e, press_valid, held);
                n_fail++;
            end
        end
    endtask

    task automatic test_single_press;
        logic       exp_v;
        logic [2:0] exp_id;
        logic [3:0] exp_h;
        press_ready = 1'b1;
        b2 = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick;
            exp_v  = (e == 20);
            exp_id = exp_v ? 3'd2 : 3'd0;
            exp_h  = (e >= 18) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (press_valid !== exp_v || press_id !== exp_id) begin
                $display("FAIL single_offer edge %0d: valid %b id %0d expected %b %0d", e, press_valid, press_id, exp_v, exp_id);
                n_fail++;
            end
            n_checks++;
            if (held !== exp_h) begin
                $display("FAIL single_held edge %0d: got %b expected %b", e, held, exp_h); n_fail++;
            end
        end
        b2 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            exp_h = (e < 18) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (press_valid !== 1'b0 || press_id !== 3'd0) begin
                $display("FAIL release_no_event edge %0d: valid %b id %0d expected 0 0", e, press_valid, press_id);
                n_fail++;
            end
            n_checks++;
            if (held !== exp_h) begin
                $display("FAIL release_held edge %0d: got %b expected %b", e, held, exp_h); n_fail++;
            end
        end
    endtask

    task automatic test_bounce;
        press_ready = 1'b1;
        for (int e = 0; e < 130; e++) begin
            b1 = (e < 100) && ((e / 10) % 2 == 0);
            tick;
            n_checks++;
            if (press_valid !== 1'b0 || held !== 4'b0000) begin
                $display("FAIL bounce edge %0d: valid %b held %b expected 0 0000", e, press_valid, held);
                n_fail++;
            end
        end
    endtask

    task automatic test_simultaneous;
        logic       exp_v;
        logic [2:0] exp_id;
        logic [3:0] exp_h;
        press_ready = 1'b1;
        b1 = 1'b1;
        b3 = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick;
            exp_v  = (e == 20) || (e == 22);
            exp_id = (e == 20) ? 3'd1 : ((e == 22) ? 3'd3 : 3'd0);
            exp_h  = (e >= 18) ? 4'b0101 : 4'b0000;
            n_checks++;
            if (press_valid !== exp_v || press_id !== exp_id) begin
                $display("FAIL simul_offer edge %0d: valid %b id %0d expected %b %0d", e, press_valid, press_id, exp_v, exp_id);
                n_fail++;
            end
            n_checks++;
            if (held !== exp_h) begin
                $display("FAIL simul_held edge %0d: got %b expected %b", e, held, exp_h); n_fail++;
            end
        end
        b1 = 1'b0;
        b3 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            n_checks++;
            if (press_valid !== 1'b0) begin
                $display("FAIL simul_release edge %0d: valid %b expected 0", e, press_valid); n_fail++;
            end
        end
        n_checks++;
        if (held !== 4'b0000) begin
            $display("FAIL simul_held_final: got %b expected 0000", held); n_fail++;
        end
    endtask

    task automatic test_stall_coalesce;
        logic       exp_v;
        logic [2:0] exp_id;
        int         acc;
        press_ready = 1'b0;
        for (int phase = 0; phase < 4; phase++) begin
            b4 = (phase % 2 == 0);
            for (int e = 1; e <= 30; e++) begin
                tick;
                exp_v  = (phase > 0) || (e >= 20);
                exp_id = exp_v ? 3'd4 : 3'd0;
                n_checks++;
                if (press_valid !== exp_v || press_id !== exp_id) begin
                    $display("FAIL stall_hold phase %0d edge %0d: valid %b id %0d expected %b %0d", phase, e, press_valid, press_id, exp_v, exp_id);
                    n_fail++;
                end
            end
        end
        press_ready = 1'b1;
        acc = 0;
        for (int e = 1; e <= 30; e++) begin
            if (press_valid && press_ready) acc++;
            tick;
            n_checks++;
            if (press_valid !== 1'b0 || press_id !== 3'd0) begin
                $display("FAIL stall_after_accept edge %0d: valid %b id %0d expected 0 0", e, press_valid, press_id);
                n_fail++;
            end
        end
        n_checks++;
        if (acc !== 1) begin
            $display("FAIL stall_accept_count: got %0d expected 1", acc); n_fail++;
        end
    endtask

    task automatic test_reset_mid_offer;
        press_ready = 1'b0;
        b2 = 1'b1;
        for (int e = 1; e <= 20; e++) tick;
        n_checks++;
        if (press_valid !== 1'b1 || press_id !== 3'd2 || held !== 4'b0010) begin
            $display("FAIL midreset_offer: valid %b id %0d held %b expected 1 2 0010", press_valid, press_id, held);
            n_fail++;
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (press_valid !== 1'b0) begin
            $display("FAIL midreset_valid: got %b expected 0", press_valid); n_fail++;
        end
        n_checks++;
        if (press_id !== 3'd0) begin
            $display("FAIL midreset_id: got %0d expected 0", press_id); n_fail++;
        end
        n_checks++;
        if (held !== 4'b0000) begin
            $display("FAIL midreset_held: got %b expected 0000", held); n_fail++;
        end
        b2 = 1'b0;
        press_ready = 1'b1;
        tick; tick;
        #2;
        rst = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick;
            n_checks++;
            if (press_valid !== 1'b0 || held !== 4'b0000) begin
                $display("FAIL midreset_quiet edge %0d: valid %b held %b expected 0 0000", e, press_valid, held);
                n_fail++;
            end
        end
    endtask

    task automatic test_held_through_reset;
        logic       exp_v;
        logic [2:0] exp_id;
        int         events;
        press_ready = 1'b1;
        b3 = 1'b1;
        tick;
        rst = 1'b0;
        tick; tick;
        #2;
        rst = 1'b1;
        events = 0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            if (press_valid) events++;
            exp_v  = (e == 20);
            exp_id = exp_v ? 3'd3 : 3'd0;
            n_checks++;
            if (press_valid !== exp_v || press_id !== exp_id) begin
                $display("FAIL thru_reset edge %0d: valid %b id %0d expected %b %0d", e, press_valid, press_id, exp_v, exp_id);
                n_fail++;
            end
        end
        b3 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            if (press_valid) events++;
        end
        n_checks++;
        if (events !== 1) begin
            $display("FAIL thru_reset_events: got %0d expected 1", events); n_fail++;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        clk         = 1'b0;
        rst         = 1'b0;
        b1          = 1'b0;
        b2          = 1'b0;
        b3          = 1'b0;
        b4          = 1'b0;
        press_ready = 1'b0;
        test_reset;
        test_single_press;
        test_bounce;
        test_simultaneous;
        test_stall_coalesce;
        test_reset_mid_offer;
        test_held_through_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
